serial_borrow_subtractor: RTL and testbench

- Multi-cycle, chunk-serial subtractor. Computes diff = a - b - bin over N bits, CHUNK bits per clock, with a ripple borrow held in a register between chunks.
- Paired with the team's adder as its arithmetic inverse. Used where a full-width single-cycle borrow chain is too long for timing.
- Valid/ready handshake on both input and output sides.

---
 rtl/serial_borrow_subtractor.sv | 147 ++++++++++++++
 tb/tb_serial_borrow_subtractor.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/serial_borrow_subtractor.sv
// Chunk-serial subtractor: diff = a - b - bin, CHUNK bits per clock, with the borrow carried in a register.
// Optional signed-overflow flag is built only when SUB_SIGNED_OVF_EN is defined.
module serial_borrow_subtractor #(
   parameter int N     = 32,
   parameter int CHUNK = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] diff,
   output logic         bout,
   output logic         overflow
);

   localparam int NCHUNK = N / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    a_sh_q, a_sh_d;
   logic [N-1:0]    b_sh_q, b_sh_d;
   logic [N-1:0]    res_q, res_d;
   logic [N-1:0]    diff_q, diff_d;
   logic            borrow_q, borrow_d;
   logic            bout_q, bout_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CHUNK:0]  step;
   logic [N-1:0]    res_next;

   // Top bit of the (CHUNK+1)-bit difference is the chunk's borrow out.
   function automatic logic [CHUNK:0] sub_chunk(input logic [CHUNK-1:0] x,
                                                input logic [CHUNK-1:0] y,
                                                input logic             bi);
      return {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bi};
   endfunction

   assign step     = sub_chunk(a_sh_q[CHUNK-1:0], b_sh_q[CHUNK-1:0], borrow_q);
   assign res_next = (res_q >> CHUNK) | (N'(step[CHUNK-1:0]) << (N - CHUNK));

`ifdef SUB_SIGNED_OVF_EN
   logic a_sign_q, a_sign_d;
   logic b_sign_q, b_sign_d;
   logic ovf_q, ovf_d;
`endif

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;
      cnt_d    = cnt_q;
`ifdef SUB_SIGNED_OVF_EN
      a_sign_d = a_sign_q;
      b_sign_d = b_sign_q;
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d   = a;
               b_sh_d   = b;
               borrow_d = bin;
               cnt_d    = '0;
`ifdef SUB_SIGNED_OVF_EN
               a_sign_d = a[N-1];
               b_sign_d = b[N-1];
`endif
               state_d  = RUN;
            end
         end
         RUN: begin
            a_sh_d   = a_sh_q >> CHUNK;
            b_sh_d   = b_sh_q >> CHUNK;
            res_d    = res_next;
            borrow_d = step[CHUNK];
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(NCHUNK - 1)) begin
               diff_d  = res_next;
               bout_d  = step[CHUNK];
`ifdef SUB_SIGNED_OVF_EN
               ovf_d   = (a_sign_q != b_sign_q) & (res_next[N-1] != a_sign_q);
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef SUB_SIGNED_OVF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sign_q <= 1'b0;
         b_sign_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         a_sign_q <= a_sign_d;
         b_sign_q <= b_sign_d;
         ovf_q    <= ovf_d;
      end
   end
   assign overflow = ovf_q;
`else
   assign overflow = 1'b0;
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign diff      = diff_q;
   assign bout      = bout_q;

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Randomized bench for serial_borrow_subtractor against a plain-arithmetic reference model.
module tb_serial_borrow_subtractor;

   localparam int N      = 32;
   localparam int CHUNK  = 8;
   localparam int NCHUNK = N / CHUNK;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         bin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [N-1:0] diff;
   logic         bout;
   logic         overflow;

   int checks = 0;
   int errors = 0;

   serial_borrow_subtractor #(.N(N), .CHUNK(CHUNK)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic mbin,
                                 output logic [N-1:0] md, output logic mbo, output logic mov);
      longint ua, ub;
      ua  = longint'(ma);
      ub  = longint'(mb);
      md  = N'(ua - ub - longint'(mbin));
      mbo = (ua < ub + longint'(mbin));
`ifdef SUB_SIGNED_OVF_EN
      mov = (ma[N-1] != mb[N-1]) && (md[N-1] != ma[N-1]);
`else
      mov = 1'b0;
`endif
   endfunction

   // Called on a negedge with the DUT idle.
   task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tbin,
                        input int hold);
      logic [N-1:0] ed;
      logic         eb, eo;
      int           lat;
      model(ta, tb, tbin, ed, eb, eo);
      chk("idle_in_ready", in_ready, 1);
      a = ta; b = tb; bin = tbin; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = $urandom; b = $urandom; bin = 1'(($urandom));
      chk("run_in_ready", in_ready, 0);
      chk("run_out_valid", out_valid, 0);
      lat = 0;
      while (!out_valid && lat <= 20) begin
         @(negedge clk);
         lat++;
         a = $urandom; b = $urandom;
      end
      chk("latency", N'(lat), N'(NCHUNK));
      if (!out_valid) return;
      chk("diff", diff, ed);
      chk("bout", bout, eb);
      chk("overflow", overflow, eo);
      chk("done_in_ready", in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_out_valid", out_valid, 1);
         chk("hold_diff", diff, ed);
         chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("ret_in_ready", in_ready, 1);
      chk("ret_out_valid", out_valid, 0);
      @(negedge clk);
      chk("idle_keep_diff", diff, ed);
      chk("idle_keep_bout", bout, eb);
   endtask

   initial begin
      logic [N-1:0] ra, rb;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_diff", diff, 0);
      chk("rst_bout", bout, 0);
      chk("rst_overflow", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_no_start", in_ready, 1);

      do_op(32'd5, 32'd3, 1'b0, 0);
      do_op(32'd0, 32'd1, 1'b0, 0);
      do_op(32'h0000_0100, 32'd0, 1'b1, 0);
      do_op(32'd7, 32'd9, 1'b0, 10);
      do_op(32'h8000_0000, 32'd1, 1'b0, 0);
      do_op(32'h1234_5678, 32'h1234_5678, 1'b0, 0);
      do_op(32'd0, 32'd0, 1'b1, 0);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1);
      do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);

      for (int k = 0; k < 30; k++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = ra;
            1: rb = ra + 1;
            2: rb = {ra[N-1:CHUNK], 8'h00} | N'($urandom_range(0, 255));
            default: rb = $urandom;
         endcase
         do_op(ra, rb, 1'($urandom), $urandom_range(0, 3));
      end

      // Abort an operation two cycles into RUN.
      a = 32'hFFFF_FFFF; b = 32'd1; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_diff", diff, 0);
      chk("abort_bout", bout, 0);
      chk("abort_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_abort_in_ready", in_ready, 1);
      do_op(32'd9, 32'd4, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
